// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB-first operands.
// Optional subtract mode (A + ~B + 1) is compiled in with SERIAL_ADDER_SUB_EN.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             a,
    input  logic             b,
    output logic             s,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sub_q, sub_d;

    logic             sub_w;
    logic             inv_sel;
    logic             cin;
    logic             b_eff;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Bit 0 takes its mode and carry-in straight from the start cycle; later bits use the held copies.
    assign inv_sel = (state_q == IDLE) ? sub_w : sub_q;
    assign cin     = (state_q == IDLE) ? sub_w : carry_q;
    assign b_eff   = b ^ inv_sel;
    assign fa_s    = a ^ b_eff ^ cin;
    assign fa_c    = (a & b_eff) | (a & cin) | (b_eff & cin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sub_d   = sub_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sub_d   = sub_w;
                    s_d     = fa_s;
                    carry_d = fa_c;
                    sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                    cnt_d   = CW'(1);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = fa_s;
                carry_d = fa_c;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s    = s_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: directed cases plus random operands
// checked against an arithmetic reference; subtract cases under SERIAL_ADDER_SUB_EN.
module tb_serial_adder_fsm;

    localparam int W = 8;

    logic         clk;
    logic         clk_en;
    logic         rst;
    logic         start;
    logic         sub;
    logic         a;
    logic         b;
    logic         s;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .s     (s),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams one operation starting at the next falling edge and checks every serial bit and the result.
    // ign_at > 0 pulses start while the operation is in flight at that bit index.
    task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                          input logic sb, input int ign_at, input string tag);
        logic [W:0] full;
        int         busy_cnt;
        busy_cnt = 0;
        if (sb) full = {1'b0, opa} + {1'b0, ~opb} + (W+1)'(1);
        else    full = {1'b0, opa} + {1'b0, opb};
        @(negedge clk);
        start = 1'b1;
        sub   = sb;
        a     = opa[0];
        b     = opb[0];
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            chk({tag, "_s"}, 64'(s), 64'(full[k-1]));
            if (busy) busy_cnt++;
            start = (k == ign_at);
            sub   = ~sb;
            a     = opa[k];
            b     = opb[k];
        end
        @(negedge clk);
        start = 1'b0;
        a     = 1'($urandom);
        b     = 1'($urandom);
        chk({tag, "_s_last"}, 64'(s), 64'(full[W-1]));
        chk({tag, "_done"},   64'(done), 64'(1));
        chk({tag, "_busy"},   64'(busy), 64'(0));
        chk({tag, "_sum"},    64'(sum), 64'(full[W-1:0]));
        chk({tag, "_cout"},   64'(cout), 64'(full[W]));
        chk({tag, "_busycnt"}, 64'(busy_cnt), 64'(W - 1));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] rsum_hold;
        logic         rcout_hold;
        checks = 0;
        errors = 0;
        clk_en = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        a      = 1'b0;
        b      = 1'b0;
        rst    = 1'b1;
        #12;
        chk("rst_s",    64'(s),    64'(0));
        chk("rst_sum",  64'(sum),  64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h33, 1'b0, 0, "add_5a_33");
        run_op(8'hFF, 8'h01, 1'b0, 0, "ovf_ff_01");
        run_op(8'h80, 8'h80, 1'b0, 0, "ovf_80_80");

        // Asynchronous reset with the clock stopped while outputs are non-zero.
        run_op(8'h7E, 8'h81, 1'b0, 0, "pre_rst");
        clk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s",    64'(s),    64'(0));
        chk("arst_sum",  64'(sum),  64'(0));
        chk("arst_cout", 64'(cout), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        rst = 1'b0;
        #2;
        clk_en = 1'b1;

        // Abort 0xAA+0x55 after bit 3 has been consumed.
        ra = 8'hAA;
        rb = 8'h55;
        @(negedge clk);
        start = 1'b1;
        a     = ra[0];
        b     = rb[0];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            a     = ra[k];
            b     = rb[k];
        end
        @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("abort_s",    64'(s),    64'(0));
        chk("abort_sum",  64'(sum),  64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        #1;
        rst = 1'b0;
        run_op(8'h0F, 8'h01, 1'b0, 0, "post_abort");

        run_op(8'h12, 8'h34, 1'b0, 3, "ign_start");
        run_op(8'h01, 8'h01, 1'b0, 0, "b2b");
        @(negedge clk);
        chk("b2b_done_drop", 64'(done), 64'(0));
        chk("b2b_sum_hold",  64'(sum),  64'(8'h02));

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 0, "sub_10_01");
        run_op(8'h01, 8'h02, 1'b1, 0, "sub_01_02");
`endif

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, int'($urandom_range(0, W - 1)), "rand");
            rsum_hold  = sum;
            rcout_hold = cout;
            if (rs) rsum_hold = W'({1'b0, ra} + {1'b0, ~rb} + (W+1)'(1));
            else    rsum_hold = W'({1'b0, ra} + {1'b0, rb});
            rcout_hold = rs ? (ra >= rb) : (({1'b0, ra} + {1'b0, rb}) > (W+1)'((1 << W) - 1));
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                @(negedge clk);
                a = 1'($urandom);
                b = 1'($urandom);
                chk("rand_idle_done", 64'(done), 64'(0));
                chk("rand_hold_sum",  64'(sum),  64'(rsum_hold));
                chk("rand_hold_cout", 64'(cout), 64'(rcout_hold));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
